// File: rtl/calc_seq_alu.sv
// Multi-cycle BCD calculator core: digit-serial BCD->binary conversion, then add/sub/mul/div/concat.
// Optional remainder output for div when CALC_REM_EN is defined.
module calc_seq_alu #(
  parameter int unsigned NDIG = 2,
  parameter int unsigned OPW  = 7,
  parameter int unsigned RESW = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [4*NDIG-1:0] a_bcd_i,
  input  logic [4*NDIG-1:0] b_bcd_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [RESW-1:0]   result_o,
  output logic              negative_o,
  output logic              dot_o,
`ifdef CALC_REM_EN
  output logic [OPW-1:0]    remainder_o,
`endif
  output logic              err_o
);

  typedef enum logic [2:0] {StIdle, StConv, StCheck, StExec, StFin} state_e;

  localparam int unsigned CntW = $clog2(OPW + NDIG + 1);

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam logic [RESW-1:0] Pow10 = RESW'(pow10(NDIG));

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [4*NDIG-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [OPW-1:0]      a_acc_q, a_acc_d, b_acc_q, b_acc_d;
  logic                bad_q, bad_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [RESW-1:0]     prod_q, prod_d, mcand_q, mcand_d;
  logic [OPW-1:0]      mplier_q, mplier_d, quo_q, quo_d, prem_q, prem_d;
  logic [RESW-1:0]     result_q, result_d;
  logic                neg_q, neg_d, dot_q, dot_d, err_q, err_d;
  logic [OPW-1:0]      rem_q, rem_d;

  logic [3:0]          a_dig, b_dig;
  logic [RESW-1:0]     prod_nxt, exec_res;
  logic [OPW:0]        trial;
  logic                fits, exec_last, exec_neg;
  logic [OPW-1:0]      prem_nxt, quo_nxt;

  assign a_dig = a_sh_q[4*NDIG-1 -: 4];
  assign b_dig = b_sh_q[4*NDIG-1 -: 4];

  // One shift-add multiply step and one restoring-divide step per EXEC cycle.
  assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign trial    = {prem_q, quo_q[OPW-1]};
  assign fits     = trial >= {1'b0, b_acc_q};
  assign prem_nxt = fits ? OPW'(trial - {1'b0, b_acc_q}) : trial[OPW-1:0];
  assign quo_nxt  = {quo_q[OPW-2:0], fits};

  assign exec_last = (op_q == 3'd2 || op_q == 3'd3) ? (cnt_q == CntW'(OPW - 1)) : 1'b1;
  assign exec_neg  = (op_q == 3'd1) && (b_acc_q > a_acc_q);

  always_comb begin
    exec_res = '0;
    case (op_q)
      3'd0:    exec_res = RESW'(a_acc_q) + RESW'(b_acc_q);
      3'd1:    exec_res = exec_neg ? RESW'(b_acc_q - a_acc_q) : RESW'(a_acc_q - b_acc_q);
      3'd2:    exec_res = prod_nxt;
      3'd3:    exec_res = RESW'(quo_nxt);
      3'd4:    exec_res = RESW'(a_acc_q) * Pow10 + RESW'(b_acc_q);
      default: exec_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    a_acc_d  = a_acc_q;
    b_acc_d  = b_acc_q;
    bad_d    = bad_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    quo_d    = quo_q;
    prem_d   = prem_q;
    result_d = result_q;
    neg_d    = neg_q;
    dot_d    = dot_q;
    err_d    = err_q;
    rem_d    = rem_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          op_d    = op_i;
          a_sh_d  = a_bcd_i;
          b_sh_d  = b_bcd_i;
          a_acc_d = '0;
          b_acc_d = '0;
          bad_d   = 1'b0;
          cnt_d   = '0;
          state_d = StConv;
        end
      end
      StConv: begin
        a_acc_d = OPW'(a_acc_q * OPW'(10)) + OPW'(a_dig);
        b_acc_d = OPW'(b_acc_q * OPW'(10)) + OPW'(b_dig);
        a_sh_d  = a_sh_q << 4;
        b_sh_d  = b_sh_q << 4;
        bad_d   = bad_q | (a_dig > 4'd9) | (b_dig > 4'd9);
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(NDIG - 1)) begin
          cnt_d   = '0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (bad_q || op_q > 3'd4 || (op_q == 3'd3 && b_acc_q == '0)) begin
          err_d    = 1'b1;
          result_d = '0;
          neg_d    = 1'b0;
          dot_d    = 1'b0;
          rem_d    = '0;
          state_d  = StFin;
        end else begin
          prod_d   = '0;
          mcand_d  = RESW'(a_acc_q);
          mplier_d = b_acc_q;
          quo_d    = a_acc_q;
          prem_d   = '0;
          cnt_d    = '0;
          state_d  = StExec;
        end
      end
      StExec: begin
        prod_d   = prod_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        quo_d    = quo_nxt;
        prem_d   = prem_nxt;
        cnt_d    = cnt_q + CntW'(1);
        if (exec_last) begin
          result_d = exec_res;
          neg_d    = exec_neg;
          dot_d    = (op_q != 3'd4);
          err_d    = 1'b0;
          rem_d    = (op_q == 3'd3) ? prem_nxt : '0;
          state_d  = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      a_acc_q  <= '0;
      b_acc_q  <= '0;
      bad_q    <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      quo_q    <= '0;
      prem_q   <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      dot_q    <= 1'b0;
      err_q    <= 1'b0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      a_acc_q  <= a_acc_d;
      b_acc_q  <= b_acc_d;
      bad_q    <= bad_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      quo_q    <= quo_d;
      prem_q   <= prem_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      dot_q    <= dot_d;
      err_q    <= err_d;
      rem_q    <= rem_d;
    end
  end

  assign busy_o     = (state_q == StConv) || (state_q == StCheck) || (state_q == StExec);
  assign done_o     = (state_q == StFin);
  assign result_o   = result_q;
  assign negative_o = neg_q;
  assign dot_o      = dot_q;
  assign err_o      = err_q;
`ifdef CALC_REM_EN
  assign remainder_o = rem_q;
`else
  // Without the remainder port the partial remainder is only a divide intermediate.
  logic unused_rem;
  assign unused_rem = ^rem_q;
`endif

endmodule
